// File: rtl/draw_glyph_renderer.sv
// Glyph pixel renderer: fetches a bitmap row per ROM access and emits one pixel per cycle.
// Optional macro OPAQUE_BG_EN: clear bitmap bits are painted with BG_COLOUR instead of skipped.
module draw_glyph_renderer #(
  parameter int          GLYPH_W   = 8,
  parameter int          GLYPH_H   = 12,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int          SCREEN_W  = 320,
  parameter int          SCREEN_H  = 240
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_draw,
  input  logic [8:0]         x_in,
  input  logic [7:0]         y_in,
  input  logic [4:0]         obj_type,
  output logic [8:0]         rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic               plot,
  output logic [8:0]         x_out,
  output logic [7:0]         y_out,
  output logic [2:0]         colour,
  output logic               draw_object_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DRAW,
    S_DONE,
    S_RELEASE
  } state_e;

  localparam logic [3:0] COL_LAST = 4'(GLYPH_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(GLYPH_H - 1);
  localparam logic [9:0] X_LIMIT  = 10'(SCREEN_W);
  localparam logic [8:0] Y_LIMIT  = 9'(SCREEN_H);

  state_e             state_q,    state_d;
  logic [3:0]         row_q,      row_d;
  logic [3:0]         col_q,      col_d;
  logic [8:0]         x_base_q,   x_base_d;
  logic [7:0]         y_base_q,   y_base_d;
  logic [4:0]         type_q,     type_d;
  logic [GLYPH_W-1:0] row_buf_q,  row_buf_d;
  logic [8:0]         rom_addr_q, rom_addr_d;

  // Pixel datapath signals
  logic [9:0]         x_sum;
  logic [8:0]         y_sum;
  logic               in_screen;
  logic [GLYPH_W-1:0] row_shifted;
  logic               pix_bit;

  // NOTE: every signal is given a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    x_base_d   = x_base_q;
    y_base_d   = y_base_q;
    type_d     = type_q;
    row_buf_d  = row_buf_q;
    rom_addr_d = rom_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start_draw) begin
          x_base_d   = x_in;
          y_base_d   = y_in;
          type_d     = obj_type;
          row_d      = 4'd0;
          rom_addr_d = {obj_type, 4'd0};
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        row_buf_d = rom_data;
        col_d     = 4'd0;
        state_d   = S_DRAW;
      end
      S_DRAW: begin
        if (col_q == COL_LAST) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d      = row_q + 4'd1;
            rom_addr_d = {type_q, row_q + 4'd1};
            state_d    = S_FETCH;
          end
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the requester to drop start so a single request never draws twice.
        if (!start_draw) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      x_base_q   <= '0;
      y_base_q   <= '0;
      type_q     <= '0;
      row_buf_q  <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      x_base_q   <= x_base_d;
      y_base_q   <= y_base_d;
      type_q     <= type_d;
      row_buf_q  <= row_buf_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Sums are one bit wider than the screen coordinates so an overflow still clips.
  always_comb begin
    x_sum       = {1'b0, x_base_q} + {6'd0, col_q};
    y_sum       = {1'b0, y_base_q} + {5'd0, row_q};
    in_screen   = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
    row_shifted = row_buf_q << col_q;
    pix_bit     = row_shifted[GLYPH_W-1];
  end

  always_comb begin
    plot   = 1'b0;
    x_out  = 9'd0;
    y_out  = 8'd0;
    colour = 3'b000;
    if (state_q == S_DRAW) begin
      x_out = x_sum[8:0];
      y_out = y_sum[7:0];
`ifdef OPAQUE_BG_EN
      plot   = in_screen;
      colour = in_screen ? (pix_bit ? FG_COLOUR : BG_COLOUR) : 3'b000;
`else
      plot   = pix_bit && in_screen;
      colour = (pix_bit && in_screen) ? FG_COLOUR : 3'b000;
`endif
    end
  end

  assign rom_addr         = rom_addr_q;
  assign draw_object_done = (state_q == S_DONE);

endmodule
